// File: rtl/uart_pkg.sv
// Shared constants, enums and helpers for the UART packet pattern generator.
package uart_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] LFSR_MASK = 8'hB8;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_GAP     = 3'd5
  } pstate_t;

  // Sub-phases of the checksum state: send the byte, wait for its stop bit, end-of-packet cycle.
  typedef enum logic [1:0] {
    CS_SEND = 2'd0,
    CS_WAIT = 2'd1,
    CS_END  = 2'd2
  } csum_ph_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned div_calc(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit; each bit DIV cycles.
// tx is bit 0 of the frame shift register, so it is registered and idles high.
module uart_tx_core #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = 4;

  logic          active_q, active_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          bit_end;
  logic          frame_end;

  assign bit_end   = (baud_q == CW'(DIV - 1));
  assign frame_end = active_q && bit_end && (bit_q == BW'(9));
  assign in_ready  = !active_q || frame_end;
  assign tx        = shreg_q[0];

  // Baud counter, bit counter and frame shifting; new byte may load on the stop bit's last cycle.
  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    if (active_q) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
      if (bit_end && (bit_q != BW'(9))) begin
        bit_d   = bit_q + BW'(1);
        shreg_d = {1'b1, shreg_q[9:1]};
      end
    end
    if (in_ready) begin
      if (in_valid) begin
        active_d = 1'b1;
        baud_d   = '0;
        bit_d    = '0;
        shreg_d  = {1'b1, in_data, 1'b0};
      end else if (active_q) begin
        active_d = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
        shreg_d  = '1;
      end
    end
  end

  // Serializer state registers; reset drives the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

endmodule

// File: rtl/uart_pattern_tx.sv
// Framed UART pattern generator: 0xA5, len, payload pattern, checksum; single-shot or continuous.
module uart_pattern_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned GAP_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  mode,
  input  logic [7:0]  len,
  input  logic [7:0]  seed,
  output logic        tx,
  output logic        busy,
  output logic        pkt_done,
  output logic [15:0] pkt_count,
  output logic [7:0]  cur_byte
);

  localparam int unsigned DIV = div_calc(CLK_HZ, BAUD);
  localparam int unsigned GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_pattern_tx: CLK_HZ/BAUD gives fewer than 2 cycles per bit");
  end

  pstate_t       state_q, state_d;
  csum_ph_t      phase_q, phase_d;
  mode_t         mode_q, mode_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    pat_q, pat_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          busy_q, busy_d;
  logic          pkt_done_q, pkt_done_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic [7:0]    cur_byte_q, cur_byte_d;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          load_pkt;

  // Next payload value for the captured pattern.
  function automatic logic [7:0] pat_next(input mode_t m, input logic [7:0] p);
    case (m)
      MODE_INCR:  return p + 8'd1;
      MODE_CONST: return p;
      MODE_LFSR:  return p[0] ? ((p >> 1) ^ LFSR_MASK) : (p >> 1);
      default:    return {p[6:0], p[7]};
    endcase
  endfunction

  // LFSR and walking-one patterns would lock up on an all-zero seed.
  function automatic logic [7:0] seed_fix(input mode_t m, input logic [7:0] s);
    if (((m == MODE_LFSR) || (m == MODE_WALK)) && (s == 8'd0)) return 8'd1;
    return s;
  endfunction

  uart_tx_core #(.DIV(DIV)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (tx_valid),
    .in_data  (tx_data),
    .in_ready (tx_ready),
    .tx       (tx)
  );

  // Packet FSM, pattern generator, checksum, gap and packet counters.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    len_d       = len_q;
    pat_d       = pat_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    pkt_done_d  = 1'b0;
    pkt_count_d = pkt_count_q;
    cur_byte_d  = cur_byte_q;
    tx_valid    = 1'b0;
    tx_data     = HDR_BYTE;
    load_pkt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) load_pkt = 1'b1;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) state_d = ST_LEN;
      end
      ST_LEN: begin
        tx_valid = 1'b1;
        tx_data  = len_q;
        if (tx_ready) state_d = (len_q == 8'd0) ? ST_CSUM : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = pat_q;
        if (tx_ready) begin
          pat_d  = pat_next(mode_q, pat_q);
          csum_d = csum_q + pat_q;
          idx_d  = idx_q + 8'd1;
          if (idx_q == (len_q - 8'd1)) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        case (phase_q)
          CS_SEND: begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
            if (tx_ready) phase_d = CS_WAIT;
          end
          CS_WAIT: begin
            // Core is mid-frame here, so ready marks the checksum stop bit's last cycle.
            if (tx_ready) begin
              phase_d     = CS_END;
              pkt_done_d  = 1'b1;
              pkt_count_d = pkt_count_q + 16'd1;
            end
          end
          default: begin
            phase_d = CS_SEND;
            if (!continuous) begin
              state_d = ST_IDLE;
            end else if (GAP_CYCLES == 0) begin
              load_pkt = 1'b1;
            end else begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end
        endcase
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (continuous) load_pkt = 1'b1;
          else            state_d  = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_pkt) begin
      state_d = ST_HDR;
      mode_d  = mode_t'(mode);
      len_d   = len;
      pat_d   = seed_fix(mode_t'(mode), seed);
      csum_d  = '0;
      idx_d   = '0;
    end

    if (tx_valid && tx_ready) cur_byte_d = tx_data;
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= CS_SEND;
      mode_q      <= MODE_INCR;
      len_q       <= '0;
      pat_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_count_q <= '0;
      cur_byte_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      busy_q      <= busy_d;
      pkt_done_q  <= pkt_done_d;
      pkt_count_q <= pkt_count_d;
      cur_byte_q  <= cur_byte_d;
    end
  end

  assign busy      = busy_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_count = pkt_count_q;
  assign cur_byte  = cur_byte_q;

endmodule

// File: tb/tb_uart_pattern_tx.sv
// Bench for uart_pattern_tx: decodes tx with a UART receiver and compares to a packet model.
module tb_uart_pattern_tx;

  localparam int unsigned CLK_HZ = 400;
  localparam int unsigned BAUD   = 100;
  localparam int unsigned GAP    = 8;
  localparam int unsigned DIV    = 4;
  localparam int unsigned FRAME  = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  len = 8'd0;
  logic [7:0]  seed = 8'd0;
  logic        tx;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_count;
  logic [7:0]  cur_byte;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  uart_pattern_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .continuous(continuous),
    .mode      (mode),
    .len       (len),
    .seed      (seed),
    .tx        (tx),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_count (pkt_count),
    .cur_byte  (cur_byte)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and UART receiver sampling each bit mid-way.
  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [7:0]  rx_q[$];
  logic [7:0]  cur_q[$];
  int unsigned fall_q[$];
  int unsigned done_q[$];
  logic        busy_done_q[$];
  logic        busy_next_q[$];
  logic [7:0]  exp_q[$];
  int unsigned frame_err = 0;
  logic        in_frame = 1'b0;
  logic        prev_tx = 1'b1;
  logic        done_prev = 1'b0;
  logic [7:0]  sh = 8'd0;
  int unsigned bcnt = 0;
  int unsigned f_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      prev_tx   = 1'b1;
      done_prev = 1'b0;
    end else begin
      if (done_prev) busy_next_q.push_back(busy);
      if (pkt_done) begin
        done_q.push_back(cyc_n);
        busy_done_q.push_back(busy);
      end
      done_prev = pkt_done;
      if (!in_frame && prev_tx && !tx) begin
        in_frame = 1'b1;
        bcnt     = 0;
        f_cyc    = cyc_n;
        cur_q.push_back(cur_byte);
      end
      if (in_frame) begin
        if (bcnt >= DIV && bcnt < 9 * DIV && (bcnt % DIV) == DIV / 2) sh = {tx, sh[7:1]};
        if (bcnt == 9 * DIV + DIV / 2) begin
          if (!tx) frame_err++;
          rx_q.push_back(sh);
          fall_q.push_back(f_cyc);
          in_frame = 1'b0;
        end
        bcnt++;
      end
      prev_tx = tx;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    rx_q.delete();
    fall_q.delete();
    cur_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (done_q.size() < target && k < budget) begin
      tick(1);
      k++;
    end
    if (done_q.size() < target) check_eq("timeout_pkt_done", done_q.size(), target);
  endtask

  task automatic wait_falls(input int unsigned target, input int unsigned budget);
    int unsigned k = 0;
    while (fall_q.size() < target && k < budget) begin
      tick(1);
      k++;
    end
    if (fall_q.size() < target) check_eq("timeout_tx_frame", fall_q.size(), target);
  endtask

  // Reference packet built directly from the pattern definitions.
  task automatic model_push(input logic [1:0] m, input logic [7:0] l, input logic [7:0] s);
    logic [7:0]  p;
    logic [7:0]  s_eff;
    logic [15:0] w;
    int unsigned sum;
    s_eff = s;
    if ((m == 2'd2 || m == 2'd3) && s == 8'd0) s_eff = 8'd1;
    sum = 0;
    p   = s_eff;
    exp_q.push_back(8'hA5);
    exp_q.push_back(l);
    for (int i = 0; i < int'(l); i++) begin
      case (m)
        2'd0: p = 8'(int'(s_eff) + i);
        2'd1: p = s_eff;
        2'd2: if (i > 0) p = p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
        default: begin
          w = 16'({s_eff, s_eff} << (i % 8));
          p = w[15:8];
        end
      endcase
      sum = sum + 32'(p);
      exp_q.push_back(p);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic check_bytes();
    check_eq("n_bytes", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) begin
        check_eq($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
        check_eq($sformatf("cur_byte%0d", i), cur_q[i], exp_q[i]);
      end
    end
  endtask

  // One single-shot packet; optional mid-packet input changes and a start while busy.
  task automatic run_single(input logic [1:0] m, input logic [7:0] l, input logic [7:0] s,
                            input logic disturb);
    int unsigned t0;
    int unsigned nd;
    clear_q();
    nd         = done_q.size();
    mode       = m;
    len        = l;
    seed       = s;
    continuous = 1'b0;
    start      = 1'b1;
    t0         = cyc_n;
    tick(1);
    start = 1'b0;
    check_eq("busy_rise", busy, 1);
    if (disturb) begin
      tick(60);
      mode  = ~m;
      seed  = s ^ 8'h5A;
      len   = l + 8'd7;
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    wait_done(nd + 1, (32'(l) + 3) * FRAME + 100);
    tick(20);
    model_push(m, l, s);
    exp_count = exp_count + 16'd1;
    check_bytes();
    if (fall_q.size() > 0) begin
      check_eq("tx_fall_latency", fall_q[0] - t0, 2);
      if (done_q.size() > nd)
        check_eq("pkt_duration", done_q[nd] - fall_q[0], (32'(l) + 3) * FRAME);
    end
    check_eq("pkt_done_pulses", done_q.size(), nd + 1);
    check_eq("pkt_count", pkt_count, exp_count);
    if (busy_next_q.size() > 0) begin
      check_eq("busy_at_done", busy_done_q[$], 1);
      check_eq("busy_after_done", busy_next_q[$], 0);
    end
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned nd;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pkt_done", pkt_done, 0);
    check_eq("rst_pkt_count", pkt_count, 0);
    check_eq("rst_cur_byte", cur_byte, 0);
    #20;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Directed packets: INCR, zero-length CONST
    run_single(2'd0, 8'd3, 8'h10, 1'b0);
    run_single(2'd1, 8'd0, 8'h55, 1'b0);

    // Continuous WALK, continuous cleared during the second packet
    clear_q();
    nd         = done_q.size();
    mode       = 2'd3;
    len        = 8'd4;
    seed       = 8'h01;
    continuous = 1'b1;
    start      = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(nd + 1, 400);
    wait_falls(9, 200);
    continuous = 1'b0;
    wait_done(nd + 2, 400);
    tick(60);
    model_push(2'd3, 8'd4, 8'h01);
    model_push(2'd3, 8'd4, 8'h01);
    exp_count = exp_count + 16'd2;
    check_bytes();
    if (fall_q.size() > 7 && done_q.size() > nd)
      check_eq("gap_cycles", fall_q[7] - done_q[nd], GAP + 2);
    check_eq("cont_pkt_done_pulses", done_q.size(), nd + 2);
    check_eq("cont_pkt_count", pkt_count, exp_count);
    check_eq("cont_busy_idle", busy, 0);

    // LFSR zero seed with mid-packet input changes and start while busy
    run_single(2'd2, 8'd3, 8'h00, 1'b1);

    // Randomized packets
    for (int k = 0; k < 6; k++)
      run_single(2'($urandom_range(0, 3)), 8'($urandom_range(0, 12)), 8'($urandom),
                 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a payload data bit
    clear_q();
    mode  = 2'd1;
    len   = 8'd4;
    seed  = 8'h00;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_falls(3, 200);
    tick(9);
    #2;
    check_eq("pre_reset_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", tx, 1);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_pkt_count", pkt_count, 0);
    check_eq("async_rst_pkt_done", pkt_done, 0);
    tick(3);
    rst_n     = 1'b1;
    exp_count = 16'd0;
    tick(2);
    run_single(2'd0, 8'd5, 8'hFE, 1'b0);

    // Packet counter wrap from a preloaded 0xFFFF
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFF;
    tick(2);
    @(negedge clk);
    release dut.pkt_count_q;
    tick(1);
    check_eq("preload_count", pkt_count, 16'hFFFF);
    exp_count = 16'hFFFF;
    run_single(2'd3, 8'd2, 8'h80, 1'b0);

    check_eq("stop_bit_errors", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
